// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse key timing controller: FSM state encoding,
// default timing parameters (in 100 ms ticks), symbol/letter widths and a
// saturating increment helper for the tick counter.
// -----------------------------------------------------------------------------
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS     = 2'd1,
      GAP       = 2'd2,
      WORD_WAIT = 2'd3
   } state_t;

   localparam int DEF_DASH_TICKS = 3;
   localparam int DEF_LETTER_GAP = 3;
   localparam int DEF_WORD_GAP   = 7;

   localparam int MAX_SYMS = 6;
   localparam int CODE_W   = 6;
   localparam int LEN_W    = 3;
   localparam int CNT_W    = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/morse_sym_shift.sv
// -----------------------------------------------------------------------------
// morse_sym_shift
// Accumulates the symbols of the letter being keyed.
//   clk, rst : clock, asynchronous active-low reset
//   push     : one symbol was classified this cycle
//   dash     : type of the pushed symbol (1 = dash)
//   clear    : letter closed; start a new one
//   code     : symbols so far, right-aligned, bit0 = most recent
//   len      : number of symbols stored (0..6)
//   err      : sticky, set when a symbol arrived while already full
//   full     : six symbols stored; further pushes are dropped
// -----------------------------------------------------------------------------
module morse_sym_shift
   import morse_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              dash,
   input  logic              clear,
   output logic [CODE_W-1:0] code,
   output logic [LEN_W-1:0]  len,
   output logic              err,
   output logic              full
);

   assign full = (len == LEN_W'(MAX_SYMS));

   // Shift register, length counter and overflow flag for the open letter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         code <= '0;
         len  <= '0;
         err  <= 1'b0;
      end else if (clear) begin
         code <= '0;
         len  <= '0;
         err  <= 1'b0;
      end else if (push) begin
         if (!full) begin
            code <= {code[CODE_W-2:0], dash};
            len  <= len + LEN_W'(1);
         end else begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/morse_timing_ctrl.sv
// -----------------------------------------------------------------------------
// morse_timing_ctrl
// Classifies key presses into dots/dashes and release times into letter and
// word boundaries, all measured in ticks of an external 100 ms timer.
//   clk, rst     : clock, asynchronous active-low reset
//   tick         : one-cycle pulse per time unit
//   key          : synchronized, debounced key (1 = pressed)
//   timer_clr    : one-cycle restart of the tick timer on every accepted edge
//   sym_valid    : one-cycle pulse, a symbol was classified (sym_dash = type)
//   letter_valid : one-cycle pulse, letter_code/len/err updated and held
//   word_gap     : one-cycle pulse, word boundary reached
// WORD_GAP must be larger than LETTER_GAP.
// -----------------------------------------------------------------------------
module morse_timing_ctrl
   import morse_pkg::*;
#(
   parameter int DASH_TICKS = DEF_DASH_TICKS,
   parameter int LETTER_GAP = DEF_LETTER_GAP,
   parameter int WORD_GAP   = DEF_WORD_GAP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              key,
   output logic              timer_clr,
   output logic              sym_valid,
   output logic              sym_dash,
   output logic              letter_valid,
   output logic [CODE_W-1:0] letter_code,
   output logic [LEN_W-1:0]  letter_len,
   output logic              letter_err,
   output logic              word_gap
);

   localparam logic [CNT_W-1:0] DASH_T   = CNT_W'(DASH_TICKS);
   localparam logic [CNT_W-1:0] LETTER_T = CNT_W'(LETTER_GAP);
   localparam logic [CNT_W-1:0] WORD_T   = CNT_W'(WORD_GAP);

   state_t             state_r;
   logic               key_q_r;
   logic [CNT_W-1:0]   tick_cnt_r;

   logic               rise_s;
   logic               fall_s;
   logic [CNT_W-1:0]   cnt_inc_s;
   logic               dash_s;
   logic               push_s;
   logic               close_s;
   logic [CODE_W-1:0]  code_s;
   logic [LEN_W-1:0]   len_s;
   logic               err_s;
   logic               full_s;

   // Edge detection and the strobes shared with the symbol shift register.
   // An accepted edge always wins over a coincident tick, so close_s is
   // suppressed when a rise arrives in the same cycle.
   always_comb begin
      rise_s    = key & ~key_q_r;
      fall_s    = ~key & key_q_r;
      cnt_inc_s = sat_inc(tick_cnt_r);
      dash_s    = (tick_cnt_r >= DASH_T);
      push_s    = 1'b0;
      close_s   = 1'b0;
      if (state_r == PRESS) begin
         push_s = fall_s;
      end else begin
         push_s = 1'b0;
      end
      if ((state_r == GAP) && !rise_s && tick && (cnt_inc_s == LETTER_T)) begin
         close_s = 1'b1;
      end else begin
         close_s = 1'b0;
      end
   end

   morse_sym_shift u_shift (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .dash  (dash_s),
      .clear (close_s),
      .code  (code_s),
      .len   (len_s),
      .err   (err_s),
      .full  (full_s)
   );

   // Timing FSM, tick counter and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         key_q_r      <= 1'b0;
         tick_cnt_r   <= '0;
         timer_clr    <= 1'b0;
         sym_valid    <= 1'b0;
         sym_dash     <= 1'b0;
         letter_valid <= 1'b0;
         letter_code  <= '0;
         letter_len   <= '0;
         letter_err   <= 1'b0;
         word_gap     <= 1'b0;
      end else begin
         key_q_r      <= key;
         timer_clr    <= 1'b0;
         sym_valid    <= 1'b0;
         letter_valid <= 1'b0;
         word_gap     <= 1'b0;
         case (state_r)
            IDLE: begin
               if (rise_s) begin
                  state_r    <= PRESS;
                  tick_cnt_r <= '0;
                  timer_clr  <= 1'b1;
               end
            end
            PRESS: begin
               if (fall_s) begin
                  state_r    <= GAP;
                  tick_cnt_r <= '0;
                  timer_clr  <= 1'b1;
                  // A symbol beyond the sixth is dropped, so it is not reported.
                  sym_valid  <= ~full_s;
                  sym_dash   <= dash_s;
               end else if (tick) begin
                  tick_cnt_r <= cnt_inc_s;
               end
            end
            GAP: begin
               if (rise_s) begin
                  state_r    <= PRESS;
                  tick_cnt_r <= '0;
                  timer_clr  <= 1'b1;
               end else if (tick) begin
                  // Count keeps running into WORD_WAIT: word gap is total release time.
                  tick_cnt_r <= cnt_inc_s;
                  if (close_s) begin
                     state_r      <= WORD_WAIT;
                     letter_valid <= 1'b1;
                     letter_code  <= code_s;
                     letter_len   <= len_s;
                     letter_err   <= err_s;
                  end
               end
            end
            WORD_WAIT: begin
               if (rise_s) begin
                  state_r    <= PRESS;
                  tick_cnt_r <= '0;
                  timer_clr  <= 1'b1;
               end else if (tick) begin
                  tick_cnt_r <= cnt_inc_s;
                  if (cnt_inc_s == WORD_T) begin
                     state_r  <= IDLE;
                     word_gap <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
